input_debouncer_multi: RTL and testbench
========================================

Name: input_debouncer_multi

Overview:
- Parametrised N-channel button/switch conditioner for the FCVM input path.
- Each channel does the following:
  - synchronises an asynchronous pin;
  - debounces it with a configurable stability window;
  - optionally inverts polarity;
  - emits single-cycle press, release and auto-repeat strobes.
- Sits between the raw controller/keypad pins and the input register block. Replaces the single-channel debouncer that has no reset and only a level output.

Parameters:
- CHANNELS, 8, number of independent input channels (>=1).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a new level (>=1; 50000 = 10 ms at 5 MHz).
- ACTIVE_LOW, 1, 1: pin low = pressed (inputs inverted before sync); 0: pin high = pressed.
- REPEAT_DELAY, 2500000, held cycles after press before the first repeat strobe (0 disables auto-repeat).
- REPEAT_RATE, 500000, cycles between subsequent repeat strobes (>=1; ignored when REPEAT_DELAY=0).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_in  in  CHANNELS  raw asynchronous pin levels.
- btn_state  out  CHANNELS  debounced level, 1 = pressed (after polarity).
- btn_press  out  CHANNELS  1-cycle strobe on accepted released->pressed.
- btn_release  out  CHANNELS  1-cycle strobe on accepted pressed->released.
- btn_repeat  out  CHANNELS  1-cycle auto-repeat strobe while held.
- any_event  out  1  registered OR of all press/release/repeat strobes, asserted in the same cycle as those strobes.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - btn_state, btn_press, btn_release, btn_repeat and any_event are all 0.
  - Sync flops and the accepted level are set to "released" (logical 0 after polarity).
  - All counters are set to 0.
  - rst asserted mid-count or mid-hold aborts everything. No strobe fires during or on release of reset.
- Polarity: p = ACTIVE_LOW ? ~btn_in : btn_in. Applied per bit before synchronisation.
- Synchroniser: 2 flops per channel (s1 <= p; s = s1 <= s1). No logic sits between the two flops.
- Debounce, per channel. Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If s == btn_state: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: btn_state <= s, cnt <= 0, and the press or release strobe asserts in that same cycle.
  - Else: cnt <= cnt+1.
  - Any single-cycle return of s to btn_state restarts the window from 0.
- Latency: btn_state and the strobe update on the (DEBOUNCE_CYCLES+2)th rising edge. Edge 1 is the first edge that samples the new pin level.
- Strobes are registered outputs, high for exactly one cycle, and 0 otherwise.
- Auto-repeat, per channel. Active only when REPEAT_DELAY>0. Uses a repeat counter and a phase bit (DELAY/RATE).
  - On the press-acceptance cycle: rcnt <= 0, phase <= DELAY.
  - While btn_state==1 and no press is being accepted:
    - in DELAY, when rcnt == REPEAT_DELAY-1: btn_repeat pulses, rcnt <= 0, phase <= RATE;
    - in RATE, when rcnt == REPEAT_RATE-1: btn_repeat pulses, rcnt <= 0;
    - otherwise rcnt <= rcnt+1.
  - When btn_state==0: rcnt <= 0, phase <= DELAY, and no repeat.
  - btn_repeat never coincides with btn_press or btn_release on the same channel.
  - First repeat asserts REPEAT_DELAY cycles after the btn_press cycle. Subsequent repeats are every REPEAT_RATE cycles.
- Channels are fully independent. Simultaneous events on several channels all assert in the same cycle.
- Counters never wrap: each is compared against its terminal value before incrementing.

Test Plan:
(CHANNELS=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_RATE=3 unless noted.)
- Reset: hold rst 3 cycles with btn_in=4'b0000 (all pressed) -> all outputs 0 during reset; btn_state=4'b1111 with one btn_press=4'b1111 pulse at edge 6 after rst drops; any_event=1 that cycle only.
- Clean press: btn_in[0] 1->0 before edge 1 -> btn_state[0]=1 and btn_press[0]=1 after edge 6 only. Release 0->1 -> btn_release[0] after 6 edges.
- Bounce: btn_in[1] toggles 0/1 every 2 cycles for 20 cycles, then stays 0 -> no strobes during bouncing; btn_press[1] exactly 6 edges after the final transition.
- Auto-repeat: hold ch2 pressed 30 cycles after btn_press -> btn_repeat[2] at +10, +13, +16, +19, +22, +25, +28 cycles. Release -> repeats stop, then btn_release. Re-press -> first repeat again at +10.
- Simultaneous and reset mid-count: press ch0 and ch3 on the same cycle -> both btn_press bits in one cycle. Assert rst when cnt=2 -> no strobe, btn_state=0. With REPEAT_DELAY=0, a 50-cycle hold gives btn_repeat always 0.

Source files
------------

// File: rtl/input_debouncer_multi.sv
// N-channel button conditioner: polarity, 2-flop sync, stability-window debounce,
// and registered press / release / auto-repeat strobes per channel.
module input_debouncer_multi #(
    parameter int CHANNELS        = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_DELAY    = 2500000,
    parameter int REPEAT_RATE     = 500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_state,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_repeat,
    output logic                any_event
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = (RMAX > 1) ? $clog2(RMAX + 1) : 1;
    localparam logic [0:0] PH_DELAY = 1'b0;
    localparam logic [0:0] PH_RATE  = 1'b1;

    logic [CHANNELS-1:0] pol;
    logic [CHANNELS-1:0] sync1_reg;
    logic [CHANNELS-1:0] sync2_reg;
    logic [CHANNELS-1:0] press_set;
    logic [CHANNELS-1:0] release_set;
    logic [CHANNELS-1:0] repeat_set;
    logic                any_event_reg;

    assign pol = ACTIVE_LOW ? ~btn_in : btn_in;

    // Plain flop-to-flop synchroniser; reset value 0 means "released".
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pol;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [CW-1:0] cnt_reg;
            logic          state_reg;
            logic          press_reg;
            logic          release_reg;
            logic          differs;
            logic          accept;

            assign differs           = (sync2_reg[gi] != state_reg);
            assign accept            = differs && (cnt_reg == CNT_LAST);
            assign press_set[gi]     = accept && sync2_reg[gi];
            assign release_set[gi]   = accept && !sync2_reg[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg     <= '0;
                    state_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    press_reg   <= press_set[gi];
                    release_reg <= release_set[gi];
                    if (!differs) begin
                        cnt_reg <= '0;
                    end else if (accept) begin
                        state_reg <= sync2_reg[gi];
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end

            assign btn_state[gi]   = state_reg;
            assign btn_press[gi]   = press_reg;
            assign btn_release[gi] = release_reg;

            if (REPEAT_DELAY > 0) begin : g_rpt
                localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
                localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
                logic [RW-1:0] rcnt_reg;
                logic [0:0]    phase_reg;
                logic          repeat_reg;
                logic          hit;

                assign hit = (phase_reg == PH_DELAY) ? (rcnt_reg == DELAY_LAST)
                                                     : (rcnt_reg == RATE_LAST);
                // A release being accepted wins over a due repeat so they never coincide.
                assign repeat_set[gi] = state_reg && !release_set[gi] && hit;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        rcnt_reg   <= '0;
                        phase_reg  <= PH_DELAY;
                        repeat_reg <= 1'b0;
                    end else begin
                        repeat_reg <= repeat_set[gi];
                        if (press_set[gi] || release_set[gi] || !state_reg) begin
                            rcnt_reg  <= '0;
                            phase_reg <= PH_DELAY;
                        end else if (hit) begin
                            rcnt_reg  <= '0;
                            phase_reg <= PH_RATE;
                        end else begin
                            rcnt_reg <= rcnt_reg + RW'(1);
                        end
                    end
                end

                assign btn_repeat[gi] = repeat_reg;
            end else begin : g_no_rpt
                assign repeat_set[gi] = 1'b0;
                assign btn_repeat[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            any_event_reg <= 1'b0;
        end else begin
            any_event_reg <= |(press_set | release_set | repeat_set);
        end
    end

    assign any_event = any_event_reg;

endmodule

// File: tb/tb_input_debouncer_multi.sv
// Scoreboard bench for input_debouncer_multi: expected strobes are queued by cycle
// when pins are driven and compared every cycle against the DUT outputs.
module tb_input_debouncer_multi;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_in  = 4'b0000;
    logic [3:0] btn_in2 = 4'b1111;
    logic [3:0] btn_state, btn_press, btn_release, btn_repeat;
    logic       any_event;
    logic [3:0] nr_state, nr_press, nr_release, nr_repeat;
    logic       nr_any;

    always #5 clk = ~clk;

    input_debouncer_multi #(
        .CHANNELS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1),
        .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .btn_state(btn_state), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .any_event(any_event)
    );

    input_debouncer_multi #(
        .CHANNELS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1),
        .REPEAT_DELAY(0), .REPEAT_RATE(3)
    ) dut_nr (
        .clk(clk), .rst(rst), .btn_in(btn_in2),
        .btn_state(nr_state), .btn_press(nr_press), .btn_release(nr_release),
        .btn_repeat(nr_repeat), .any_event(nr_any)
    );

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rpt;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_p, exp_r, exp_t;
    logic [3:0] exp_s = 4'b0000;

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] t);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.rpt = t;
        exp_q.push_back(e);
    endtask

    // Collects every strobe scheduled for the current cycle and advances the expected level.
    task automatic pop_expected();
        exp_p = '0; exp_r = '0; exp_t = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                exp_p |= exp_q[i].press;
                exp_r |= exp_q[i].rel;
                exp_t |= exp_q[i].rpt;
                exp_q.delete(i);
            end
        end
        exp_s = (exp_s | exp_p) & ~exp_r;
    endtask

    task automatic test_reset();
        int c;
        for (int i = 0; i < 3; i++) begin
            tick(); pop_expected(); checks++;
            if ({btn_state, btn_press, btn_release, btn_repeat, any_event} !== 17'd0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got st=%b p=%b r=%b t=%b a=%b want all 0",
                         cyc, btn_state, btn_press, btn_release, btn_repeat, any_event);
            end
        end
        rst = 1'b0;
        c = cyc;
        push_ev(c + 6, 4'b1111, 4'b0000, 4'b0000);
        push_ev(c + 12, 4'b0000, 4'b1111, 4'b0000);
        while (cyc < c + 15) begin
            tick(); pop_expected(); checks++;
            if ({btn_state, btn_press, btn_release, btn_repeat, any_event} !==
                {exp_s, exp_p, exp_r, exp_t, |{exp_p, exp_r, exp_t}}) begin
                errors++;
                $display("FAIL reset_release cyc=%0d got st=%b p=%b r=%b t=%b a=%b want st=%b p=%b r=%b t=%b",
                         cyc, btn_state, btn_press, btn_release, btn_repeat, any_event, exp_s, exp_p, exp_r, exp_t);
            end
            if (cyc == c + 6) btn_in = 4'b1111;
        end
    endtask

    task automatic test_clean_press();
        int c;
        c = cyc;
        btn_in[0] = 1'b0;
        push_ev(c + 6, 4'b0001, 4'b0000, 4'b0000);
        push_ev(c + 12, 4'b0000, 4'b0001, 4'b0000);
        while (cyc < c + 15) begin
            tick(); pop_expected(); checks++;
            if ({btn_state, btn_press, btn_release, btn_repeat, any_event} !==
                {exp_s, exp_p, exp_r, exp_t, |{exp_p, exp_r, exp_t}}) begin
                errors++;
                $display("FAIL clean_press cyc=%0d got st=%b p=%b r=%b t=%b a=%b want st=%b p=%b r=%b t=%b",
                         cyc, btn_state, btn_press, btn_release, btn_repeat, any_event, exp_s, exp_p, exp_r, exp_t);
            end
            if (cyc == c + 6) btn_in[0] = 1'b1;
        end
    endtask

    task automatic test_bounce();
        int c;
        for (int k = 0; k < 10; k++) begin
            btn_in[1] = (k % 2 == 1);
            for (int j = 0; j < 2; j++) begin
                tick(); pop_expected(); checks++;
                if ({btn_state, btn_press, btn_release, btn_repeat, any_event} !==
                    {exp_s, exp_p, exp_r, exp_t, |{exp_p, exp_r, exp_t}}) begin
                    errors++;
                    $display("FAIL bounce_quiet cyc=%0d got st=%b p=%b r=%b t=%b a=%b want no events",
                             cyc, btn_state, btn_press, btn_release, btn_repeat, any_event);
                end
            end
        end
        c = cyc;
        btn_in[1] = 1'b0;
        push_ev(c + 6, 4'b0010, 4'b0000, 4'b0000);
        push_ev(c + 12, 4'b0000, 4'b0010, 4'b0000);
        while (cyc < c + 15) begin
            tick(); pop_expected(); checks++;
            if ({btn_state, btn_press, btn_release, btn_repeat, any_event} !==
                {exp_s, exp_p, exp_r, exp_t, |{exp_p, exp_r, exp_t}}) begin
                errors++;
                $display("FAIL bounce_settle cyc=%0d got st=%b p=%b r=%b t=%b a=%b want st=%b p=%b r=%b t=%b",
                         cyc, btn_state, btn_press, btn_release, btn_repeat, any_event, exp_s, exp_p, exp_r, exp_t);
            end
            if (cyc == c + 6) btn_in[1] = 1'b1;
        end
    endtask

    task automatic test_auto_repeat();
        int p;
        p = cyc + 6;
        btn_in[2] = 1'b0;
        // First hold: pin released at p+24, release accepted at p+30.
        push_ev(p, 4'b0100, 4'b0000, 4'b0000);
        for (int t = p + 10; t < p + 30; t += 3) push_ev(t, 4'b0000, 4'b0000, 4'b0100);
        push_ev(p + 30, 4'b0000, 4'b0100, 4'b0000);
        // Re-press: pin down at p+30, pressed at p+36, pin up at p+47, released at p+53.
        push_ev(p + 36, 4'b0100, 4'b0000, 4'b0000);
        for (int t = p + 46; t < p + 53; t += 3) push_ev(t, 4'b0000, 4'b0000, 4'b0100);
        push_ev(p + 53, 4'b0000, 4'b0100, 4'b0000);
        while (cyc < p + 56) begin
            tick(); pop_expected(); checks++;
            if ({btn_state, btn_press, btn_release, btn_repeat, any_event} !==
                {exp_s, exp_p, exp_r, exp_t, |{exp_p, exp_r, exp_t}}) begin
                errors++;
                $display("FAIL auto_repeat cyc=%0d (press+%0d) got st=%b p=%b r=%b t=%b a=%b want st=%b p=%b r=%b t=%b",
                         cyc, cyc - p, btn_state, btn_press, btn_release, btn_repeat, any_event, exp_s, exp_p, exp_r, exp_t);
            end
            if (cyc == p + 24) btn_in[2] = 1'b1;
            if (cyc == p + 30) btn_in[2] = 1'b0;
            if (cyc == p + 47) btn_in[2] = 1'b1;
        end
    endtask

    task automatic test_simultaneous();
        int c;
        c = cyc;
        btn_in[0] = 1'b0;
        btn_in[3] = 1'b0;
        push_ev(c + 6, 4'b1001, 4'b0000, 4'b0000);
        push_ev(c + 12, 4'b0000, 4'b1001, 4'b0000);
        while (cyc < c + 15) begin
            tick(); pop_expected(); checks++;
            if ({btn_state, btn_press, btn_release, btn_repeat, any_event} !==
                {exp_s, exp_p, exp_r, exp_t, |{exp_p, exp_r, exp_t}}) begin
                errors++;
                $display("FAIL simultaneous cyc=%0d got st=%b p=%b r=%b t=%b a=%b want st=%b p=%b r=%b t=%b",
                         cyc, btn_state, btn_press, btn_release, btn_repeat, any_event, exp_s, exp_p, exp_r, exp_t);
            end
            if (cyc == c + 6) begin
                btn_in[0] = 1'b1;
                btn_in[3] = 1'b1;
            end
        end
    endtask

    task automatic test_reset_mid_count();
        int c;
        c = cyc;
        btn_in[0] = 1'b0;
        // Reset lands while the window count is 2; the pin stays pressed so a fresh
        // window must start only once reset is released.
        push_ev(c + 12, 4'b0001, 4'b0000, 4'b0000);
        push_ev(c + 18, 4'b0000, 4'b0001, 4'b0000);
        while (cyc < c + 21) begin
            tick(); pop_expected(); checks++;
            if ({btn_state, btn_press, btn_release, btn_repeat, any_event} !==
                {exp_s, exp_p, exp_r, exp_t, |{exp_p, exp_r, exp_t}}) begin
                errors++;
                $display("FAIL reset_mid_count cyc=%0d got st=%b p=%b r=%b t=%b a=%b want st=%b p=%b r=%b t=%b",
                         cyc, btn_state, btn_press, btn_release, btn_repeat, any_event, exp_s, exp_p, exp_r, exp_t);
            end
            if (cyc == c + 4) rst = 1'b1;
            if (cyc == c + 6) rst = 1'b0;
            if (cyc == c + 12) btn_in[0] = 1'b1;
        end
    endtask

    task automatic test_no_repeat();
        int c;
        logic [3:0] want_p, want_r;
        c = cyc;
        btn_in2[0] = 1'b0;
        while (cyc < c + 66) begin
            tick();
            want_p = (cyc == c + 6)  ? 4'b0001 : 4'b0000;
            want_r = (cyc == c + 62) ? 4'b0001 : 4'b0000;
            checks++;
            if ({nr_press, nr_release, nr_repeat, nr_any} !== {want_p, want_r, 4'b0000, |{want_p, want_r}}) begin
                errors++;
                $display("FAIL no_repeat cyc=%0d got p=%b r=%b t=%b a=%b want p=%b r=%b t=0000",
                         cyc, nr_press, nr_release, nr_repeat, nr_any, want_p, want_r);
            end
            if (cyc == c + 56) btn_in2[0] = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_simultaneous();
        test_reset_mid_count();
        test_no_repeat();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending events want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
